// File: rtl/count_pkg.sv
// count_pkg
// Shared types and constants for the count step sequencer.
//   state_t : sequencer FSM encoding (INIT, PAUSE, RUN)
//   speed_t : speed level, 0 (slowest) .. SPEED_MAX (fastest)
//   next_speed() : saturating speed update from up/down pulses
package count_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_PAUSE = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    typedef logic [1:0] speed_t;

    localparam speed_t SPEED_MAX = 2'd2;

    // Pressing both buttons in the same cycle cancels out.
    function automatic speed_t next_speed(input speed_t cur,
                                          input logic   up,
                                          input logic   down);
        speed_t nxt;
        nxt = cur;
        if (up && !down && (cur != SPEED_MAX)) begin
            nxt = cur + 2'd1;
        end else if (down && !up && (cur != 2'd0)) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen
// Divides clk down to a one-cycle step event whose period depends on the
// selected speed level.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   run       : tick advances only while high; otherwise it holds
//   speed     : selects the period (TICK_SLOW / TICK_MID / TICK_FAST)
//   restart   : forces the tick back to 0 (used on a speed change)
//   step      : high during the cycle in which the tick reaches period-1
module step_tick_gen
    import count_pkg::*;
#(
    parameter int TICK_W    = 25,
    parameter int TICK_SLOW = 33554432,
    parameter int TICK_MID  = 16777216,
    parameter int TICK_FAST = 8388608
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   run,
    input  speed_t speed,
    input  logic   restart,
    output logic   step
);

    localparam logic [TICK_W-1:0] LAST_SLOW = TICK_W'(TICK_SLOW - 1);
    localparam logic [TICK_W-1:0] LAST_MID  = TICK_W'(TICK_MID - 1);
    localparam logic [TICK_W-1:0] LAST_FAST = TICK_W'(TICK_FAST - 1);

    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] last;

    always_comb begin
        last = LAST_FAST;
        case (speed)
            2'd0:    last = LAST_SLOW;
            2'd1:    last = LAST_MID;
            default: last = LAST_FAST;
        endcase
    end

    assign step = run && (tick == last);

    // A restart takes priority so a new speed always begins a full period.
    // A step on the same edge as a restart is still reported, since it
    // completed under the old period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else if (restart) begin
            tick <= '0;
        end else if (run) begin
            if (step) begin
                tick <= '0;
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/count_step_sequencer.sv
// count_step_sequencer
// Sequences the up/down display counter: owns run/pause, speed level and the
// effective count direction, and emits one-cycle count-enable strobes.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start_stop  : one-cycle pulse, toggles run/pause
//   dir_in      : level, 0 = up, 1 = down
//   speed_up    : one-cycle pulse, speed + 1 (saturates at 2)
//   speed_down  : one-cycle pulse, speed - 1 (saturates at 0)
//   at_max      : counter is at its maximum
//   at_min      : counter is at zero
//   cnt_en      : one-cycle step strobe to the counter
//   cnt_up      : effective direction, 1 = increment
//   cnt_clr     : clear strobe, high only in INIT
//   speed       : current speed level
//   running     : high in RUN
// Build option: define COUNT_STEP_AUTO_REVERSE_EN to make the counter bounce
// between its limits instead of stopping at them.
module count_step_sequencer
    import count_pkg::*;
#(
    parameter int TICK_W    = 25,
    parameter int TICK_SLOW = 33554432,
    parameter int TICK_MID  = 16777216,
    parameter int TICK_FAST = 8388608
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       dir_in,
    input  logic       speed_up,
    input  logic       speed_down,
    input  logic       at_max,
    input  logic       at_min,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_clr,
    output logic [1:0] speed,
    output logic       running
);

    state_t state;
    state_t state_next;
    speed_t speed_q;
    speed_t speed_nxt;
    logic   speed_change;
    logic   step;
    logic   at_limit;
    logic   rev;

    assign speed_nxt    = next_speed(speed_q, speed_up, speed_down);
    assign speed_change = (speed_nxt != speed_q);
    assign speed        = speed_q;

    step_tick_gen #(
        .TICK_W   (TICK_W),
        .TICK_SLOW(TICK_SLOW),
        .TICK_MID (TICK_MID),
        .TICK_FAST(TICK_FAST)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .run    (state == ST_RUN),
        .speed  (speed_q),
        .restart(speed_change),
        .step   (step)
    );

    assign cnt_up   = ~(dir_in ^ rev);
    assign at_limit = cnt_up ? at_max : at_min;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            speed_q <= '0;
            cnt_en  <= 1'b0;
        end else begin
            state   <= state_next;
            speed_q <= speed_nxt;
            cnt_en  <= step && !at_limit;
        end
    end

    // INIT exists only to give the datapath a single clear cycle after reset.
    // A start_stop that coincides with a step leaves RUN after the step has
    // already been registered into cnt_en.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        running    = 1'b0;
        case (state)
            ST_INIT: begin
                cnt_clr    = 1'b1;
                state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start_stop) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                running = 1'b1;
                if (start_stop) begin
                    state_next = ST_PAUSE;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

`ifdef COUNT_STEP_AUTO_REVERSE_EN
    logic dir_q;

    // A step blocked at a boundary reverses direction instead of idling.
    // Any operator change of dir_in wins and hands control back to dir_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev   <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_in;
            if (dir_in != dir_q) begin
                rev <= 1'b0;
            end else if (step && at_limit) begin
                rev <= ~rev;
            end
        end
    end
`else
    assign rev = 1'b0;
`endif

endmodule

// File: tb/tb_count_step_sequencer.sv
// tb_count_step_sequencer
// Directed bench for count_step_sequencer with short tick periods
// (slow = 8, mid = 4, fast = 2 clocks per step).
module tb_count_step_sequencer;

    logic       clk;
    logic       rst;
    logic       start_stop;
    logic       dir_in;
    logic       speed_up;
    logic       speed_down;
    logic       at_max;
    logic       at_min;
    logic       cnt_en;
    logic       cnt_up;
    logic       cnt_clr;
    logic [1:0] speed;
    logic       running;

    int total = 0;
    int bad   = 0;

    count_step_sequencer #(
        .TICK_W   (4),
        .TICK_SLOW(8),
        .TICK_MID (4),
        .TICK_FAST(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .dir_in    (dir_in),
        .speed_up  (speed_up),
        .speed_down(speed_down),
        .at_max    (at_max),
        .at_min    (at_min),
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .cnt_clr   (cnt_clr),
        .speed     (speed),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until cnt_en is seen high; 0 means it never came.
    task automatic wait_en(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (cnt_en) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        tick();
        start_stop = 1'b0;
    endtask

    task automatic pulse_speed(input logic up, input logic down);
        speed_up   = up;
        speed_down = down;
        tick();
        speed_up   = 1'b0;
        speed_down = 1'b0;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        start_stop = 1'b0;
        dir_in     = 1'b0;
        speed_up   = 1'b0;
        speed_down = 1'b0;
        at_max     = 1'b0;
        at_min     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int clr_cnt;
        int en_cnt;
        int run_cnt;
        rst        = 1'b1;
        start_stop = 1'b0;
        dir_in     = 1'b0;
        speed_up   = 1'b0;
        speed_down = 1'b0;
        at_max     = 1'b0;
        at_min     = 1'b0;
        tick();
        total++;
        if ({cnt_clr, running, cnt_en, speed, cnt_up} !== 6'b1_0_0_00_1) begin
            bad++;
            $display("[TB] FAIL reset_values got clr/run/en/speed/up=%b required 100001",
                     {cnt_clr, running, cnt_en, speed, cnt_up});
        end
        rst = 1'b0;
        #1;
        total++;
        if (cnt_clr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clr_after_release got %b required 1", cnt_clr);
        end
        clr_cnt = 0;
        en_cnt  = 0;
        run_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cnt_clr) clr_cnt++;
            if (cnt_en) en_cnt++;
            if (running) run_cnt++;
        end
        total++;
        if (clr_cnt !== 0) begin
            bad++;
            $display("[TB] FAIL clr_one_cycle got %0d extra clr cycles required 0", clr_cnt);
        end
        total++;
        if (en_cnt !== 0 || run_cnt !== 0) begin
            bad++;
            $display("[TB] FAIL idle_quiet got en=%0d run=%0d required 0/0", en_cnt, run_cnt);
        end
        pulse_speed(1'b0, 1'b1);
        total++;
        if (speed !== 2'd0) begin
            bad++;
            $display("[TB] FAIL speed_floor got %0d required 0", speed);
        end
        pulse_speed(1'b1, 1'b0);
        total++;
        if (speed !== 2'd1) begin
            bad++;
            $display("[TB] FAIL speed_in_pause got %0d required 1", speed);
        end
        pulse_speed(1'b0, 1'b1);
        total++;
        if (speed !== 2'd0) begin
            bad++;
            $display("[TB] FAIL speed_back_to_0 got %0d required 0", speed);
        end
    endtask

    task automatic test_run_speed0();
        int n;
        dir_in = 1'b0;
        pulse_start();
        total++;
        if (running !== 1'b1 || cnt_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL run_entry got running=%b up=%b required 1/1", running, cnt_up);
        end
        wait_en(20, n);
        total++;
        if (n !== 8) begin
            bad++;
            $display("[TB] FAIL first_step got %0d cycles required 8", n);
        end
        tick();
        total++;
        if (cnt_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL strobe_width got cnt_en=%b required 0", cnt_en);
        end
        wait_en(20, n);
        total++;
        if (n !== 7) begin
            bad++;
            $display("[TB] FAIL slow_period got %0d cycles required 7", n);
        end
    endtask

    task automatic test_speed();
        int n;
        pulse_speed(1'b1, 1'b0);
        wait_en(20, n);
        total++;
        if (speed !== 2'd1 || n !== 4) begin
            bad++;
            $display("[TB] FAIL speed_up_1 got speed=%0d period=%0d required 1/4", speed, n);
        end
        pulse_speed(1'b1, 1'b0);
        wait_en(20, n);
        total++;
        if (speed !== 2'd2 || n !== 2) begin
            bad++;
            $display("[TB] FAIL speed_up_2 got speed=%0d period=%0d required 2/2", speed, n);
        end
        // Saturated press is not a change, so the tick keeps counting.
        pulse_speed(1'b1, 1'b0);
        wait_en(20, n);
        total++;
        if (speed !== 2'd2 || n !== 1) begin
            bad++;
            $display("[TB] FAIL speed_ceiling got speed=%0d gap=%0d required 2/1", speed, n);
        end
        pulse_speed(1'b0, 1'b1);
        wait_en(20, n);
        total++;
        if (speed !== 2'd1 || n !== 4) begin
            bad++;
            $display("[TB] FAIL speed_down got speed=%0d period=%0d required 1/4", speed, n);
        end
        pulse_speed(1'b1, 1'b1);
        wait_en(20, n);
        total++;
        if (speed !== 2'd1 || n !== 3) begin
            bad++;
            $display("[TB] FAIL speed_both got speed=%0d gap=%0d required 1/3", speed, n);
        end
    endtask

`ifndef COUNT_STEP_AUTO_REVERSE_EN
    task automatic test_suppress();
        int en_cnt;
        int n;
        at_max = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cnt_en) en_cnt++;
        end
        total++;
        if (en_cnt !== 0 || running !== 1'b1 || cnt_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL at_max_hold got en=%0d running=%b up=%b required 0/1/1",
                     en_cnt, running, cnt_up);
        end
        dir_in = 1'b1;
        #1;
        total++;
        if (cnt_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dir_down got cnt_up=%b required 0", cnt_up);
        end
        wait_en(20, n);
        total++;
        if (n !== 4 || cnt_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL resume_down got gap=%0d up=%b required 4/0", n, cnt_up);
        end
        at_max = 1'b0;
        at_min = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cnt_en) en_cnt++;
        end
        total++;
        if (en_cnt !== 0 || running !== 1'b1) begin
            bad++;
            $display("[TB] FAIL at_min_hold got en=%0d running=%b required 0/1", en_cnt, running);
        end
        at_min = 1'b0;
        dir_in = 1'b0;
    endtask
`else
    task automatic test_auto_reverse();
        int n;
        at_max = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (cnt_en !== 1'b0 || cnt_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bounce_max got en=%b up=%b required 0/0", cnt_en, cnt_up);
        end
        at_max = 1'b0;
        wait_en(20, n);
        total++;
        if (n !== 4 || cnt_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL after_bounce got gap=%0d up=%b required 4/0", n, cnt_up);
        end
        dir_in = 1'b1;
        #1;
        total++;
        if (cnt_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dir_edge_pre got up=%b required 1", cnt_up);
        end
        tick();
        total++;
        if (cnt_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rev_cleared got up=%b required 0", cnt_up);
        end
        dir_in = 1'b0;
        tick();
    endtask
`endif

    task automatic test_pause_resume();
        int en_cnt;
        int run_cnt;
        int n;
        reset_dut();
        pulse_start();
        // Tick is 4 here; the pausing edge still counts it to 5.
        for (int i = 0; i < 4; i++) tick();
        pulse_start();
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pause got running=%b required 0", running);
        end
        en_cnt  = 0;
        run_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cnt_en) en_cnt++;
            if (running) run_cnt++;
        end
        total++;
        if (en_cnt !== 0 || run_cnt !== 0) begin
            bad++;
            $display("[TB] FAIL pause_hold got en=%0d run=%0d required 0/0", en_cnt, run_cnt);
        end
        pulse_start();
        wait_en(20, n);
        total++;
        if (n !== 3) begin
            bad++;
            $display("[TB] FAIL resume_gap got %0d cycles required 3", n);
        end
        // Stop on the step cycle: the step must still come out.
        for (int i = 0; i < 7; i++) tick();
        pulse_start();
        total++;
        if (cnt_en !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stop_on_step got en=%b running=%b required 1/0", cnt_en, running);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        pulse_start();
        pulse_speed(1'b1, 1'b0);
        pulse_speed(1'b1, 1'b0);
        wait_en(20, n);
        total++;
        if (n !== 2 || speed !== 2'd2) begin
            bad++;
            $display("[TB] FAIL pre_reset got gap=%0d speed=%0d required 2/2", n, speed);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({cnt_clr, running, cnt_en, speed, cnt_up} !== 6'b1_0_0_00_1) begin
            bad++;
            $display("[TB] FAIL async_reset got clr/run/en/speed/up=%b required 100001",
                     {cnt_clr, running, cnt_en, speed, cnt_up});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_run_speed0();
        test_speed();
`ifndef COUNT_STEP_AUTO_REVERSE_EN
        test_suppress();
`else
        test_auto_reverse();
`endif
        test_pause_resume();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
